dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Arbitrates the shared data memory between the two cores of the dual-core processor. Each core's MEM stage issues single-word load/store requests. The arbiter grants one requester at a time (round-robin), drives the memory port, and returns read data with a one-cycle ack. Optional lock (read-modify-write) and timeout keep a core from stalling forever.

Parameters:
AW, 32, address width
DW, 32, data width
LOCK_MAX, 4, max consecutive locked grants to one core while the other waits
TIMEOUT, 64, cycles in ISSUE without mem_ready before abort

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
cN_req  in  1  core N (N=0,1) request; held with stable fields until cN_ack
cN_wr  in  1  1=store, 0=load
cN_lock  in  1  keep grant for this core's next request
cN_addr  in  AW  word address
cN_wdata  in  DW  store data
cN_be  in  4  byte enables
cN_rdata  out  DW  load data, valid when cN_ack=1
cN_ack  out  1  one-cycle completion pulse
cN_err  out  1  with cN_ack: access timed out
cN_stall  out  1  cN_req & ~cN_ack (combinational)
mem_req  out  1  memory access valid
mem_wr  out  1  granted core's cN_wr
mem_addr  out  AW  granted core's cN_addr
mem_wdata  out  DW  granted core's cN_wdata
mem_be  out  4  granted core's cN_be
mem_rdata  in  DW  memory read data, valid with mem_ready
mem_ready  in  1  access complete this cycle
grant_id  out  1  current/last granted core
busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset asynchronous, active-high.
- Reset values: state=IDLE, grant_id=0, last_grant=1 (core 0 wins the first tie), all acks/errs=0, cN_rdata=0, mem_req=0, lock_cnt=0, timer=0.
- FSM IDLE -> ISSUE -> RESP -> IDLE.
- IDLE arbitration:
  - Only one core requesting: that core is granted.
  - Both requesting: the core != last_grant is granted.
  - Lock override: if the previous grant had cN_lock=1, that core requests again, and lock_cnt < LOCK_MAX, it keeps the grant even if the other core requests.
  - Otherwise the other core is granted and lock_cnt clears.
  - lock_cnt increments on each locked re-grant and clears when the grant changes or lock drops.
  - Grant registers grant_id; state moves to ISSUE.
- ISSUE:
  - mem_req=1; mem_wr/addr/wdata/be are a mux of the granted core's inputs by registered grant_id.
  - On mem_ready=1: latch mem_rdata into the granted cN_rdata (loads only; stores leave rdata unchanged), set last_grant=grant_id, go to RESP.
  - Timer increments each ISSUE cycle. At timer==TIMEOUT-1 with no mem_ready: go to RESP with err flag, mem_req drops.
- RESP: cN_ack=1 for the granted core only (cN_err=1 if timed out), mem_req=0, timer clears, go to IDLE.
- Minimum latency: req at edge k, mem_ready in the first ISSUE cycle gives ack in cycle k+2. Back-to-back service of the same core is one access per 3 cycles.
- Edge cases:
  - mem_ready while IDLE/RESP: ignored.
  - Requester dropping req during ISSUE: access completes, ack still pulses.
  - The non-granted core always sees stall while requesting.
- Reset mid-access: immediate return to IDLE, mem_req=0 asynchronously, no ack issued.

Test Plan:
- c0 load addr 0x10, mem_ready 2 cycles after ISSUE with rdata 0xDEADBEEF -> c0_ack one cycle later, c0_rdata=0xDEADBEEF, c0_stall high 4 cycles, c1 outputs idle.
- c0 and c1 request together after reset, mem_ready immediate, both held -> order c0, c1, c0, c1; grant_id alternates; each ack is 1 cycle.
- c1 store 0x0000CAFE be=4'b0011 -> mem_wr=1, mem_wdata=0x0000CAFE, mem_be=0011; c1_rdata unchanged.
- c0_lock=1 continuously, both requesting, LOCK_MAX=4 -> c0 granted 5 consecutive times (1 initial + 4 locked), then c1 granted.
- mem_ready never asserted, TIMEOUT=64 -> c0_ack=1 and c0_err=1 exactly 64 ISSUE cycles after grant; mem_req low afterwards; next request served normally.
- reset pulsed during ISSUE -> mem_req=0 within the same cycle, no ack, grant_id=0; post-reset tie is granted to c0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between two cores.
// Supports locked back-to-back grants (bounded by LOCK_MAX) and an ISSUE timeout.
module dmem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int LOCK_MAX = 4,
   parameter int TIMEOUT  = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c0_req,
   input  logic          c0_wr,
   input  logic          c0_lock,
   input  logic [AW-1:0] c0_addr,
   input  logic [DW-1:0] c0_wdata,
   input  logic [3:0]    c0_be,
   output logic [DW-1:0] c0_rdata,
   output logic          c0_ack,
   output logic          c0_err,
   output logic          c0_stall,
   input  logic          c1_req,
   input  logic          c1_wr,
   input  logic          c1_lock,
   input  logic [AW-1:0] c1_addr,
   input  logic [DW-1:0] c1_wdata,
   input  logic [3:0]    c1_be,
   output logic [DW-1:0] c1_rdata,
   output logic          c1_ack,
   output logic          c1_err,
   output logic          c1_stall,
   output logic          mem_req,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [3:0]    mem_be,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          grant_id,
   output logic          busy,
   output logic [1:0]    dbg_state
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int LW = $clog2(LOCK_MAX + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

   state_t          state_q, state_d;
   logic            grant_q, grant_d;
   logic            last_q, last_d;
   logic            lock_prev_q, lock_prev_d;
   logic [LW-1:0]   lock_cnt_q, lock_cnt_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [1:0]      ack_q, ack_d;
   logic [1:0]      err_q, err_d;
   logic [DW-1:0]   rdata0_q, rdata0_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;

   logic [1:0]      req_v;
   logic [1:0]      lock_v;
   logic            gnt_wr;
   logic            keep_lock;
   logic            new_g;

   assign req_v  = {c1_req, c0_req};
   assign lock_v = {c1_lock, c0_lock};
   assign gnt_wr = grant_q ? c1_wr : c0_wr;

   // A locked core keeps the port only while it asks again and its run is not exhausted.
   assign keep_lock = lock_prev_q && req_v[grant_q] && (lock_cnt_q < LW'(LOCK_MAX));

   always_comb begin
      if (keep_lock)
         new_g = grant_q;
      else if (req_v == 2'b01)
         new_g = 1'b0;
      else if (req_v == 2'b10)
         new_g = 1'b1;
      else
         new_g = ~last_q;
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      lock_prev_d = lock_prev_q;
      lock_cnt_d  = lock_cnt_q;
      timer_d     = timer_q;
      ack_d       = 2'b00;
      err_d       = 2'b00;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      case (state_q)
         IDLE: begin
            if (|req_v) begin
               state_d     = ISSUE;
               grant_d     = new_g;
               timer_d     = '0;
               lock_prev_d = lock_v[new_g];
               if (lock_prev_q && (new_g == grant_q))
                  lock_cnt_d = (lock_cnt_q < LW'(LOCK_MAX)) ? lock_cnt_q + LW'(1) : lock_cnt_q;
               else
                  lock_cnt_d = '0;
            end
         end
         ISSUE: begin
            if (mem_ready) begin
               state_d         = RESP;
               last_d          = grant_q;
               ack_d[grant_q]  = 1'b1;
               timer_d         = '0;
               if (!gnt_wr) begin
                  if (grant_q) rdata1_d = mem_rdata;
                  else         rdata0_d = mem_rdata;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               // Abort: the requester still gets its ack, flagged as an error.
               state_d         = RESP;
               ack_d[grant_q]  = 1'b1;
               err_d[grant_q]  = 1'b1;
               timer_d         = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            timer_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         last_q      <= 1'b1;
         lock_prev_q <= 1'b0;
         lock_cnt_q  <= '0;
         timer_q     <= '0;
         ack_q       <= 2'b00;
         err_q       <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_q      <= last_d;
         lock_prev_q <= lock_prev_d;
         lock_cnt_q  <= lock_cnt_d;
         timer_q     <= timer_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign c0_ack    = ack_q[0];
   assign c1_ack    = ack_q[1];
   assign c0_err    = err_q[0];
   assign c1_err    = err_q[1];
   assign c0_rdata  = rdata0_q;
   assign c1_rdata  = rdata1_q;
   assign c0_stall  = c0_req & ~ack_q[0];
   assign c1_stall  = c1_req & ~ack_q[1];

   assign mem_req   = (state_q == ISSUE);
   assign mem_wr    = gnt_wr;
   assign mem_addr  = grant_q ? c1_addr  : c0_addr;
   assign mem_wdata = grant_q ? c1_wdata : c0_wdata;
   assign mem_be    = grant_q ? c1_be    : c0_be;

   assign grant_id  = grant_q;
   assign busy      = (state_q != IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-core traffic
// checked against a transaction-level arbitration model.
module tb_dmem_arbiter;

   localparam int AW       = 32;
   localparam int DW       = 32;
   localparam int LOCK_MAX = 4;
   localparam int TIMEOUT  = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          c0_req = 0, c0_wr = 0, c0_lock = 0;
   logic [AW-1:0] c0_addr = '0;
   logic [DW-1:0] c0_wdata = '0;
   logic [3:0]    c0_be = '0;
   logic [DW-1:0] c0_rdata;
   logic          c0_ack, c0_err, c0_stall;
   logic          c1_req = 0, c1_wr = 0, c1_lock = 0;
   logic [AW-1:0] c1_addr = '0;
   logic [DW-1:0] c1_wdata = '0;
   logic [3:0]    c1_be = '0;
   logic [DW-1:0] c1_rdata;
   logic          c1_ack, c1_err, c1_stall;
   logic          mem_req, mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [3:0]    mem_be;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_ready = 1'b0;
   logic          grant_id, busy;
   logic [1:0]    dbg_state;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LOCK_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .c0_req(c0_req), .c0_wr(c0_wr), .c0_lock(c0_lock), .c0_addr(c0_addr),
      .c0_wdata(c0_wdata), .c0_be(c0_be), .c0_rdata(c0_rdata), .c0_ack(c0_ack),
      .c0_err(c0_err), .c0_stall(c0_stall),
      .c1_req(c1_req), .c1_wr(c1_wr), .c1_lock(c1_lock), .c1_addr(c1_addr),
      .c1_wdata(c1_wdata), .c1_be(c1_be), .c1_rdata(c1_rdata), .c1_ack(c1_ack),
      .c1_err(c1_err), .c1_stall(c1_stall),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .grant_id(grant_id), .busy(busy), .dbg_state(dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int stall0_cnt = 0;

   // Reference model: who was last served, which core holds a lock and for how long.
   int            m_last;
   int            m_lock_core;
   int            m_lock_run;
   int            m_winner;
   logic [DW-1:0] m_rdata [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_last      = 1;
      m_lock_core = -1;
      m_lock_run  = 0;
      m_winner    = 0;
      m_rdata[0]  = '0;
      m_rdata[1]  = '0;
   endfunction

   function automatic int pick(input logic [1:0] r);
      if (m_lock_core >= 0 && r[m_lock_core] && m_lock_run < LOCK_MAX) return m_lock_core;
      if (r == 2'b01) return 0;
      if (r == 2'b10) return 1;
      return 1 - m_last;
   endfunction

   task automatic reset_dut();
      reset = 1'b1;
      c0_req = 0; c1_req = 0; c0_lock = 0; c1_lock = 0; c0_wr = 0; c1_wr = 0;
      mem_ready = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic rand_core(input int c);
      logic rq;
      rq = ($urandom_range(0, 3) != 0);
      if (c == 0) begin
         c0_req = rq; c0_wr = 1'($urandom_range(0, 1)); c0_lock = 1'($urandom_range(0, 1));
         c0_addr = $urandom; c0_wdata = $urandom; c0_be = 4'($urandom_range(0, 15));
      end else begin
         c1_req = rq; c1_wr = 1'($urandom_range(0, 1)); c1_lock = 1'($urandom_range(0, 1));
         c1_addr = $urandom; c1_wdata = $urandom; c1_be = 4'($urandom_range(0, 15));
      end
   endtask

   // Entered at a falling edge with the arbiter idle and requests applied; lat<0 = no mem_ready.
   task automatic run_txn(input int lat, input bit drop, input logic [DW-1:0] rd, output logic obs_g);
      logic [1:0]    r, ea;
      logic          w_wr;
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_wdata;
      logic [3:0]    w_be;
      logic [1:0]    lk;
      int            w, n_issue;
      #1;
      r  = {c1_req, c0_req};
      lk = {c1_lock, c0_lock};
      w  = pick(r);
      m_winner = w;
      if (m_lock_core == w) m_lock_run = (m_lock_run < LOCK_MAX) ? m_lock_run + 1 : m_lock_run;
      else m_lock_run = 0;
      m_lock_core = lk[w] ? w : -1;
      w_wr    = (w == 1) ? c1_wr    : c0_wr;
      w_addr  = (w == 1) ? c1_addr  : c0_addr;
      w_wdata = (w == 1) ? c1_wdata : c0_wdata;
      w_be    = (w == 1) ? c1_be    : c0_be;
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_mem_req", 64'(mem_req), 64'(0));
      chk("idle_ack", 64'({c1_ack, c0_ack}), 64'(0));
      chk("idle_stall", 64'({c1_stall, c0_stall}), 64'(r));
      if (c0_stall) stall0_cnt++;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      n_issue = (lat < 0) ? TIMEOUT : lat + 1;
      obs_g = 1'b0;
      for (int i = 0; i < n_issue; i++) begin
         @(negedge clk);
         chk("issue_mem_req", 64'(mem_req), 64'(1));
         chk("issue_grant", 64'(grant_id), 64'(w));
         chk("issue_mem_wr", 64'(mem_wr), 64'(w_wr));
         chk("issue_mem_addr", 64'(mem_addr), 64'(w_addr));
         chk("issue_mem_wdata", 64'(mem_wdata), 64'(w_wdata));
         chk("issue_mem_be", 64'(mem_be), 64'(w_be));
         chk("issue_ack", 64'({c1_ack, c0_ack}), 64'(0));
         chk("issue_stall", 64'({c1_stall, c0_stall}), 64'({c1_req, c0_req}));
         if (c0_stall) stall0_cnt++;
         if (i == 0) obs_g = grant_id;
         if (drop && i == 0) begin
            if (w == 0) c0_req = 1'b0;
            else        c1_req = 1'b0;
         end
         mem_ready = (i == lat);
         mem_rdata = (i == lat) ? rd : $urandom;
      end
      @(negedge clk);
      if (lat >= 0) begin
         if (!w_wr) m_rdata[w] = rd;
         m_last = w;
      end
      ea = 2'b01 << w;
      chk("resp_ack", 64'({c1_ack, c0_ack}), 64'(ea));
      chk("resp_err", 64'({c1_err, c0_err}), (lat < 0) ? 64'(ea) : 64'(0));
      chk("resp_c0_rdata", 64'(c0_rdata), 64'(m_rdata[0]));
      chk("resp_c1_rdata", 64'(c1_rdata), 64'(m_rdata[1]));
      chk("resp_mem_req", 64'(mem_req), 64'(0));
      chk("resp_grant", 64'(grant_id), 64'(w));
      chk("resp_stall", 64'({c1_stall, c0_stall}), 64'({c1_req, c0_req} & ~ea));
      if (c0_stall) stall0_cnt++;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      logic       g;
      logic [5:0] exp_lock;
      int         lat;
      model_reset();

      // Reset values
      @(negedge clk);
      chk("rst_mem_req", 64'(mem_req), 64'(0));
      chk("rst_grant", 64'(grant_id), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_state", 64'(dbg_state), 64'(0));
      chk("rst_ack", 64'({c1_ack, c0_ack}), 64'(0));
      chk("rst_err", 64'({c1_err, c0_err}), 64'(0));
      chk("rst_c0_rdata", 64'(c0_rdata), 64'(0));
      chk("rst_c1_rdata", 64'(c1_rdata), 64'(0));

      // c0 load with mem_ready on the third ISSUE cycle
      reset_dut();
      stall0_cnt = 0;
      c0_req = 1; c0_wr = 0; c0_addr = 32'h10; c0_be = 4'hF;
      run_txn(2, 0, 32'hDEADBEEF, g);
      chk("t1_rdata", 64'(c0_rdata), 64'(32'hDEADBEEF));
      chk("t1_stall_cycles", 64'(stall0_cnt), 64'(4));
      c0_req = 0;

      // Simultaneous requests alternate c0, c1, c0, c1
      reset_dut();
      c0_req = 1; c0_addr = 32'h100; c0_be = 4'hF;
      c1_req = 1; c1_addr = 32'h200; c1_be = 4'hF;
      for (int k = 0; k < 4; k++) begin
         run_txn(0, 0, $urandom, g);
         chk("t2_order", 64'(g), 64'(k % 2));
      end

      // c1 store leaves c1_rdata untouched
      reset_dut();
      c1_req = 1; c1_wr = 0; c1_addr = 32'h40; c1_be = 4'hF;
      run_txn(0, 0, 32'h12345678, g);
      c1_wr = 1; c1_addr = 32'h44; c1_wdata = 32'h0000CAFE; c1_be = 4'b0011;
      run_txn(1, 0, 32'hFFFFFFFF, g);
      chk("t3_c1_rdata_kept", 64'(c1_rdata), 64'(32'h12345678));
      c1_req = 0; c1_wr = 0;

      // Lock: 1 initial + LOCK_MAX locked grants to c0, then c1
      reset_dut();
      exp_lock = 6'b100000;
      c0_req = 1; c0_lock = 1; c0_addr = 32'h8;
      c1_req = 1; c1_addr = 32'hC;
      for (int k = 0; k < 6; k++) begin
         run_txn(0, 0, $urandom, g);
         chk("t4_lock_order", 64'(g), 64'(exp_lock[k]));
      end
      c0_lock = 0; c0_req = 0; c1_req = 0;

      // Timeout then normal service
      reset_dut();
      c0_req = 1; c0_wr = 0; c0_addr = 32'h30;
      run_txn(-1, 0, 32'h0, g);
      c0_addr = 32'h34;
      run_txn(1, 0, 32'hA5A5_0001, g);
      chk("t5_after_timeout_rdata", 64'(c0_rdata), 64'(32'hA5A5_0001));
      c0_req = 0;

      // Reset in the middle of c1's ISSUE
      reset_dut();
      c0_req = 1; c1_req = 1; c0_wr = 0; c1_wr = 0;
      run_txn(0, 0, $urandom, g);
      @(negedge clk);
      chk("t6_pre_grant", 64'(grant_id), 64'(1));
      chk("t6_pre_mem_req", 64'(mem_req), 64'(1));
      #1 reset = 1'b1;
      #1;
      chk("t6_async_mem_req", 64'(mem_req), 64'(0));
      chk("t6_async_grant", 64'(grant_id), 64'(0));
      chk("t6_async_busy", 64'(busy), 64'(0));
      chk("t6_async_ack", 64'({c1_ack, c0_ack}), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      run_txn(0, 0, $urandom, g);
      chk("t6_post_reset_tie", 64'(g), 64'(0));

      // Randomized traffic
      reset_dut();
      for (int t = 0; t < 150; t++) begin
         if (!c0_req || (t > 0 && m_winner == 0)) rand_core(0);
         if (!c1_req || (t > 0 && m_winner == 1)) rand_core(1);
         if (!c0_req && !c1_req) begin
            if ($urandom_range(0, 1) == 0) c0_req = 1'b1;
            else                           c1_req = 1'b1;
         end
         lat = ($urandom_range(0, 15) == 0) ? -1 : int'($urandom_range(0, 3));
         run_txn(lat, ($urandom_range(0, 7) == 0), $urandom, g);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
